// File: rtl/pipeline_pkg.sv
// +--------------------------------------------------------------------------+
// | pipeline_pkg : opcodes, control-field widths/types and control decoder   |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

package pipeline_pkg;

  localparam int WB_CTL_W = 2;
  localparam int M_CTL_W  = 3;
  localparam int EX_CTL_W = 4;

  localparam logic [5:0] R_TYPE = 6'b000000;
  localparam logic [5:0] LW     = 6'b100011;
  localparam logic [5:0] SW     = 6'b101011;
  localparam logic [5:0] BEQ    = 6'b000100;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
  } wb_ctl_t;

  typedef struct packed {
    logic branch;
    logic memread;
    logic memwrite;
  } m_ctl_t;

  typedef struct packed {
    logic       regdst;
    logic [1:0] aluop;
    logic       alusrc;
  } ex_ctl_t;

  typedef struct packed {
    wb_ctl_t wb;
    m_ctl_t  m;
    ex_ctl_t ex;
  } ctl_t;

  // Unknown opcodes decode to an all-zero bubble.
  function automatic ctl_t decode_ctl(input logic [5:0] opcode);
    ctl_t c;
    c = '0;
    case (opcode)
      R_TYPE: begin
        c.ex.regdst   = 1'b1;
        c.ex.aluop    = 2'b10;
        c.wb.regwrite = 1'b1;
      end
      LW: begin
        c.ex.alusrc   = 1'b1;
        c.m.memread   = 1'b1;
        c.wb.regwrite = 1'b1;
        c.wb.memtoreg = 1'b1;
      end
      SW: begin
        c.ex.alusrc   = 1'b1;
        c.m.memwrite  = 1'b1;
      end
      BEQ: begin
        c.ex.aluop    = 2'b01;
        c.m.branch    = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/register_file.sv
// +--------------------------------------------------------------------------+
// | register_file : 2R/1W register file, r0 hardwired to zero, async reset   |
// | Option WB_BYPASS_EN forwards a same-cycle write to the read ports.       |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module register_file #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [31:0]       rd_data1,
  output logic [31:0]       rd_data2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data
);

  logic [31:0] regs_q [DEPTH];
  logic [31:0] regs_d [DEPTH];
  logic        wr_valid;

  assign wr_valid = wr_en && (wr_addr != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_valid) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rd_data1 = (rd_addr1 == '0) ? 32'd0 : regs_q[rd_addr1];
    rd_data2 = (rd_addr2 == '0) ? 32'd0 : regs_q[rd_addr2];
`ifdef WB_BYPASS_EN
    if (wr_valid && (wr_addr == rd_addr1)) begin
      rd_data1 = wr_data;
    end
    if (wr_valid && (wr_addr == rd_addr2)) begin
      rd_data2 = wr_data;
    end
`endif
  end

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
// +--------------------------------------------------------------------------+
// | decode_stage : ID stage - control decode, register read, ID/EX latch     |
// | Option WB_BYPASS_EN (in register_file) forwards same-cycle write-back.   |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

module decode_stage
  import pipeline_pkg::*;
#(
  parameter int RF_DEPTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         id_instr,
  input  logic [31:0]         id_addr,
  input  logic                wb_reg_write,
  input  logic [4:0]          wb_write_reg,
  input  logic [31:0]         wb_write_data,
  output logic [WB_CTL_W-1:0] ex_wb_ctl,
  output logic [M_CTL_W-1:0]  ex_m_ctl,
  output logic [EX_CTL_W-1:0] ex_ex_ctl,
  output logic [31:0]         ex_npc,
  output logic [31:0]         ex_readdat1,
  output logic [31:0]         ex_readdat2,
  output logic [31:0]         ex_sign_ext,
  output logic [4:0]          ex_instr_2016,
  output logic [4:0]          ex_instr_1511
);

  localparam int RF_ADDR_W = 5;

  logic [31:0] rf_rd1;
  logic [31:0] rf_rd2;

  ctl_t        ctl_d,    ctl_q;
  logic [31:0] npc_d,    npc_q;
  logic [31:0] rd1_d,    rd1_q;
  logic [31:0] rd2_d,    rd2_q;
  logic [31:0] sext_d,   sext_q;
  logic [4:0]  rt_d,     rt_q;
  logic [4:0]  rd_d,     rd_q;

  register_file #(
    .DEPTH  (RF_DEPTH),
    .ADDR_W (RF_ADDR_W)
  ) u_register_file (
    .clk      (clk),
    .rst      (rst),
    .rd_addr1 (id_instr[25:21]),
    .rd_addr2 (id_instr[20:16]),
    .rd_data1 (rf_rd1),
    .rd_data2 (rf_rd2),
    .wr_en    (wb_reg_write),
    .wr_addr  (wb_write_reg),
    .wr_data  (wb_write_data)
  );

  always_comb begin
    ctl_d  = decode_ctl(id_instr[31:26]);
    npc_d  = id_addr;
    rd1_d  = rf_rd1;
    rd2_d  = rf_rd2;
    sext_d = {{16{id_instr[15]}}, id_instr[15:0]};
    rt_d   = id_instr[20:16];
    rd_d   = id_instr[15:11];
  end

  // ID/EX latch; reset wipes any instruction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_q  <= '0;
      npc_q  <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      sext_q <= '0;
      rt_q   <= '0;
      rd_q   <= '0;
    end else begin
      ctl_q  <= ctl_d;
      npc_q  <= npc_d;
      rd1_q  <= rd1_d;
      rd2_q  <= rd2_d;
      sext_q <= sext_d;
      rt_q   <= rt_d;
      rd_q   <= rd_d;
    end
  end

  assign ex_wb_ctl     = ctl_q.wb;
  assign ex_m_ctl      = ctl_q.m;
  assign ex_ex_ctl     = ctl_q.ex;
  assign ex_npc        = npc_q;
  assign ex_readdat1   = rd1_q;
  assign ex_readdat2   = rd2_q;
  assign ex_sign_ext   = sext_q;
  assign ex_instr_2016 = rt_q;
  assign ex_instr_1511 = rd_q;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// +--------------------------------------------------------------------------+
// | tb_decode_stage : self-checking bench for decode_stage                   |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] id_instr;
  logic [31:0] id_addr;
  logic        wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;
  logic [1:0]  ex_wb_ctl;
  logic [2:0]  ex_m_ctl;
  logic [3:0]  ex_ex_ctl;
  logic [31:0] ex_npc, ex_readdat1, ex_readdat2, ex_sign_ext;
  logic [4:0]  ex_instr_2016, ex_instr_1511;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_rf [32];
  logic [8:0]  exp_ctl;
  logic [31:0] exp_npc, exp_rd1, exp_rd2, exp_se;
  logic [4:0]  exp_rt, exp_rd;

  decode_stage #(.RF_DEPTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .id_instr      (id_instr),
    .id_addr       (id_addr),
    .wb_reg_write  (wb_reg_write),
    .wb_write_reg  (wb_write_reg),
    .wb_write_data (wb_write_data),
    .ex_wb_ctl     (ex_wb_ctl),
    .ex_m_ctl      (ex_m_ctl),
    .ex_ex_ctl     (ex_ex_ctl),
    .ex_npc        (ex_npc),
    .ex_readdat1   (ex_readdat1),
    .ex_readdat2   (ex_readdat2),
    .ex_sign_ext   (ex_sign_ext),
    .ex_instr_2016 (ex_instr_2016),
    .ex_instr_1511 (ex_instr_1511)
  );

  always #5 clk = ~clk;

  // Control word {regwrite,memtoreg, branch,memread,memwrite, regdst,aluop,alusrc}
  function automatic logic [8:0] ref_ctl(input logic [5:0] op);
    case (op)
      6'b000000: return 9'b10_000_1100;
      6'b100011: return 9'b11_010_0001;
      6'b101011: return 9'b00_001_0001;
      6'b000100: return 9'b00_100_0010;
      default:   return 9'b00_000_0000;
    endcase
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] idx, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
    if (idx == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
    if (we && wa == idx) return wd;
`endif
    return model_rf[idx];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
  endtask

  // Apply one instruction plus write-back for one clock; outputs sampled 1ns after the edge.
  task automatic cycle(input logic [31:0] instr, input logic [31:0] addr,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
    id_instr      = instr;
    id_addr       = addr;
    wb_reg_write  = we;
    wb_write_reg  = wa;
    wb_write_data = wd;
    exp_ctl = ref_ctl(instr[31:26]);
    exp_npc = addr;
    exp_rd1 = ref_read(instr[25:21], we, wa, wd);
    exp_rd2 = ref_read(instr[20:16], we, wa, wd);
    exp_se  = 32'($signed(instr[15:0]));
    exp_rt  = instr[20:16];
    exp_rd  = instr[15:11];
    @(posedge clk);
    #1;
    if (we && wa != 5'd0) model_rf[wa] = wd;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wb_reg_write = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    id_instr      = 32'h8C220004;
    id_addr       = 32'h0000_1004;
    wb_reg_write  = 1'b1;
    wb_write_reg  = 5'd1;
    wb_write_data = 32'h0000_0077;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({ex_wb_ctl, ex_m_ctl, ex_ex_ctl, ex_npc, ex_readdat1, ex_readdat2,
           ex_sign_ext, ex_instr_2016, ex_instr_1511} !== '0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: ctl=%b npc=%h rd1=%h se=%h, required all zero",
                 i, {ex_wb_ctl, ex_m_ctl, ex_ex_ctl}, ex_npc, ex_readdat1, ex_sign_ext);
      end
      @(posedge clk);
      #1;
    end
    wb_reg_write = 1'b0;
    rst = 1'b0;
    model_clear();
    // First edge after release decodes; the write attempted during reset is gone.
    cycle(32'h8C220004, 32'h0000_1004, 1'b0, 5'd0, 32'd0);
    n_checks++;
    if ({ex_wb_ctl, ex_readdat1} !== {2'b11, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_resume: wb=%b rd1=%h, required wb=11 rd1=00000000", ex_wb_ctl, ex_readdat1);
    end
  endtask

  task automatic test_lw();
    do_reset();
    cycle(32'h0, 32'h0, 1'b1, 5'd1, 32'h0000_0010);
    cycle(32'h8C220004, 32'h0000_2004, 1'b0, 5'd0, 32'd0);
    n_checks++;
    if (ex_readdat1 !== 32'h10) begin
      n_fail++; $display("FAIL lw_rd1: got %h, required 00000010", ex_readdat1);
    end
    n_checks++;
    if (ex_sign_ext !== 32'd4) begin
      n_fail++; $display("FAIL lw_sext: got %h, required 00000004", ex_sign_ext);
    end
    n_checks++;
    if ({ex_m_ctl, ex_wb_ctl, ex_ex_ctl} !== {3'b010, 2'b11, 4'b0001}) begin
      n_fail++; $display("FAIL lw_ctl: m=%b wb=%b ex=%b, required m=010 wb=11 ex=0001",
                         ex_m_ctl, ex_wb_ctl, ex_ex_ctl);
    end
    n_checks++;
    if ({ex_npc, ex_instr_2016} !== {32'h0000_2004, 5'd2}) begin
      n_fail++; $display("FAIL lw_npc_rt: npc=%h rt=%0d, required npc=00002004 rt=2", ex_npc, ex_instr_2016);
    end
  endtask

  task automatic test_rtype();
    cycle(32'h0, 32'h0, 1'b1, 5'd2, 32'd5);
    cycle(32'h0, 32'h0, 1'b1, 5'd3, 32'd7);
    cycle(32'h00430820, 32'h0000_3004, 1'b0, 5'd0, 32'd0);
    n_checks++;
    if ({ex_readdat1, ex_readdat2} !== {32'd5, 32'd7}) begin
      n_fail++; $display("FAIL rtype_regs: rd1=%h rd2=%h, required 5 and 7", ex_readdat1, ex_readdat2);
    end
    n_checks++;
    if ({ex_instr_1511, ex_ex_ctl, ex_wb_ctl, ex_m_ctl} !== {5'd1, 4'b1100, 2'b10, 3'b000}) begin
      n_fail++; $display("FAIL rtype_ctl: rd=%0d ex=%b wb=%b m=%b, required rd=1 ex=1100 wb=10 m=000",
                         ex_instr_1511, ex_ex_ctl, ex_wb_ctl, ex_m_ctl);
    end
  endtask

  task automatic test_beq_neg();
    cycle(32'h1043FFFF, 32'h0000_4004, 1'b0, 5'd0, 32'd0);
    n_checks++;
    if (ex_sign_ext !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL beq_sext: got %h, required ffffffff", ex_sign_ext);
    end
    n_checks++;
    if ({ex_m_ctl, ex_ex_ctl, ex_wb_ctl} !== {3'b100, 4'b0010, 2'b00}) begin
      n_fail++; $display("FAIL beq_ctl: m=%b ex=%b wb=%b, required m=100 ex=0010 wb=00",
                         ex_m_ctl, ex_ex_ctl, ex_wb_ctl);
    end
  endtask

  task automatic test_r0();
    cycle(32'h0, 32'h0, 1'b1, 5'd0, 32'hDEAD_BEEF);
    cycle(32'h00000820, 32'h0000_5004, 1'b1, 5'd0, 32'hDEAD_BEEF);
    n_checks++;
    if ({ex_readdat1, ex_readdat2} !== 64'd0) begin
      n_fail++; $display("FAIL r0_read: rd1=%h rd2=%h, required 0", ex_readdat1, ex_readdat2);
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] want;
    do_reset();
`ifdef WB_BYPASS_EN
    want = 32'h55;
`else
    want = 32'h0;
`endif
    cycle(32'h00800000, 32'h0, 1'b1, 5'd4, 32'h55);
    n_checks++;
    if (ex_readdat1 !== want) begin
      n_fail++; $display("FAIL same_cycle_rd: got %h, required %h", ex_readdat1, want);
    end
    cycle(32'h00800000, 32'h0, 1'b0, 5'd0, 32'd0);
    n_checks++;
    if (ex_readdat1 !== 32'h55) begin
      n_fail++; $display("FAIL next_cycle_rd: got %h, required 00000055", ex_readdat1);
    end
  endtask

  task automatic test_reset_mid();
    cycle(32'h0, 32'h0, 1'b1, 5'd9, 32'h1234_5678);
    cycle(32'h8D2A0004, 32'h0000_6004, 1'b0, 5'd0, 32'd0);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({ex_wb_ctl, ex_m_ctl, ex_ex_ctl, ex_npc, ex_readdat1, ex_readdat2,
         ex_sign_ext, ex_instr_2016, ex_instr_1511} !== '0) begin
      n_fail++; $display("FAIL async_clear: ctl=%b npc=%h rd1=%h, required all zero",
                         {ex_wb_ctl, ex_m_ctl, ex_ex_ctl}, ex_npc, ex_readdat1);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    cycle(32'h01200000, 32'h0, 1'b0, 5'd0, 32'd0);
    n_checks++;
    if (ex_readdat1 !== 32'd0) begin
      n_fail++; $display("FAIL rf_cleared: r9=%h, required 0", ex_readdat1);
    end
  endtask

  task automatic test_random();
    logic [31:0] r, instr, addr, wd;
    logic [5:0]  op;
    logic        we;
    logic [4:0]  wa;
    for (int n = 0; n < 200; n++) begin
      r = $urandom();
      case ($urandom_range(0, 4))
        0: op = 6'b000000;
        1: op = 6'b100011;
        2: op = 6'b101011;
        3: op = 6'b000100;
        default: op = 6'($urandom());
      endcase
      instr = {op, r[25:0]};
      addr  = $urandom();
      we    = 1'($urandom());
      wa    = 5'($urandom());
      wd    = $urandom();
      cycle(instr, addr, we, wa, wd);
      n_checks++;
      if ({ex_wb_ctl, ex_m_ctl, ex_ex_ctl} !== exp_ctl) begin
        n_fail++; $display("FAIL rand_ctl[%0d]: got %b, required %b (instr %h)",
                           n, {ex_wb_ctl, ex_m_ctl, ex_ex_ctl}, exp_ctl, instr);
      end
      n_checks++;
      if ({ex_readdat1, ex_readdat2} !== {exp_rd1, exp_rd2}) begin
        n_fail++; $display("FAIL rand_regs[%0d]: got %h/%h, required %h/%h",
                           n, ex_readdat1, ex_readdat2, exp_rd1, exp_rd2);
      end
      n_checks++;
      if ({ex_npc, ex_sign_ext, ex_instr_2016, ex_instr_1511} !== {exp_npc, exp_se, exp_rt, exp_rd}) begin
        n_fail++; $display("FAIL rand_fields[%0d]: npc=%h se=%h rt=%0d rd=%0d, required %h %h %0d %0d",
                           n, ex_npc, ex_sign_ext, ex_instr_2016, ex_instr_1511,
                           exp_npc, exp_se, exp_rt, exp_rd);
      end
    end
  endtask

  initial begin
    rst           = 1'b0;
    id_instr      = '0;
    id_addr       = '0;
    wb_reg_write  = 1'b0;
    wb_write_reg  = '0;
    wb_write_data = '0;
    model_clear();
    #2;
    test_reset();
    test_lw();
    test_rtype();
    test_beq_neg();
    test_r0();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
